// File: rtl/memory_access_pkg.sv
// Shared types for the memory-access pipeline stage.
//   msize_t        access size encoding (MSIZE1/2/4/8)
//   mem_state_t    memory-stage FSM states
//   execute_data_t bundle handed over by execute
//   memory_data_t  bundle handed on to writeback
//   size_mask()    byte-enable pattern of an access size, before lane shift
package memory_access_pkg;

    localparam int XLEN = 64;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } mem_state_t;

    typedef struct packed {
        logic   memread;
        logic   memwrite;
        msize_t msize;
        logic   mem_unsigned;
    } mem_ctl_t;

    typedef struct packed {
        logic            exception;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
    } ex_data_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] memdata;
        mem_ctl_t        ctl;
        ex_data_t        ex_data;
    } execute_data_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        mem_ctl_t        ctl;
        ex_data_t        ex_data;
        logic [XLEN-1:0] readdata;
    } memory_data_t;

    function automatic logic [7:0] size_mask(input msize_t s);
        case (s)
            MSIZE1:  return 8'h01;
            MSIZE2:  return 8'h03;
            MSIZE4:  return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_align.sv
// Combinational byte-lane alignment for the memory stage.
//   Store path: addr (low 3 bits), msize, memdata -> strobe, store_data
//   Load path : raw_data, addr, msize, mem_unsigned -> readdata
// Addresses are naturally aligned by the time they reach here, so an access
// never straddles the 64-bit bus word.
module memory_access_align
    import memory_access_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic [2:0]      addr,
    input  msize_t          msize,
    input  logic [DW-1:0]   memdata,
    output logic [DW/8-1:0] strobe,
    output logic [DW-1:0]   store_data,
    input  logic [DW-1:0]   raw_data,
    input  logic            mem_unsigned,
    output logic [DW-1:0]   readdata
);

    logic [5:0]    bit_off;
    logic [DW-1:0] shifted;

    assign bit_off    = {addr, 3'b000};
    assign strobe     = (DW/8)'(size_mask(msize) << addr);
    assign store_data = memdata << bit_off;
    assign shifted    = raw_data >> bit_off;

    always_comb begin
        readdata = shifted;
        case (msize)
            MSIZE1: readdata = mem_unsigned ? {{(DW-8){1'b0}},  shifted[7:0]}
                                            : {{(DW-8){shifted[7]}},  shifted[7:0]};
            MSIZE2: readdata = mem_unsigned ? {{(DW-16){1'b0}}, shifted[15:0]}
                                            : {{(DW-16){shifted[15]}}, shifted[15:0]};
            MSIZE4: readdata = mem_unsigned ? {{(DW-32){1'b0}}, shifted[31:0]}
                                            : {{(DW-32){shifted[31]}}, shifted[31:0]};
            default: readdata = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage, directly downstream of execute.
//   clk, reset (async, active-low)
//   in_valid, flush, dataE          : instruction from execute (held while data_ok=0)
//   dreq_valid/addr/size/strobe/data: data-bus request
//   dresp_addr_ok/data_ok/data      : data-bus response
//   data_ok, dataM                  : completion handshake and bundle for writeback
// Non-memory and exception-tagged instructions complete combinationally in
// IDLE. Memory ops go IDLE -> REQ -> (WAIT) -> DONE; a flushed op whose
// request was already accepted is drained through DRAIN so the bus never
// sees a second outstanding request.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int DW = 64,
    parameter int AW = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            flush,
    input  execute_data_t   dataE,
    output logic            dreq_valid,
    output logic [AW-1:0]   dreq_addr,
    output msize_t          dreq_size,
    output logic [DW/8-1:0] dreq_strobe,
    output logic [DW-1:0]   dreq_data,
    input  logic            dresp_addr_ok,
    input  logic            dresp_data_ok,
    input  logic [DW-1:0]   dresp_data,
    output logic            data_ok,
    output memory_data_t    dataM
);

    mem_state_t      state;
    logic [DW-1:0]   rdata_q;
    logic            is_mem;
    logic            bypass;
    logic            mem_start;
    logic [DW/8-1:0] st_strobe;
    logic [DW-1:0]   st_data;
    logic [DW-1:0]   ld_data;

    assign is_mem    = (dataE.ctl.memread | dataE.ctl.memwrite) & ~dataE.ex_data.exception;
    assign bypass    = in_valid & ~is_mem;
    assign mem_start = in_valid & is_mem & ~flush;

    memory_access_align #(.DW(DW)) u_align (
        .addr         (dataE.result[2:0]),
        .msize        (dataE.ctl.msize),
        .memdata      (dataE.memdata),
        .strobe       (st_strobe),
        .store_data   (st_data),
        .raw_data     (rdata_q),
        .mem_unsigned (dataE.ctl.mem_unsigned),
        .readdata     (ld_data)
    );

    // Request fields follow dataE directly; only the valid and the write
    // enables are qualified by state so nothing leaks outside REQ.
    assign dreq_valid  = (state == REQ);
    assign dreq_addr   = AW'(dataE.result);
    assign dreq_size   = dataE.ctl.msize;
    assign dreq_strobe = (state == REQ && dataE.ctl.memwrite) ? st_strobe : '0;
    assign dreq_data   = st_data;

    assign data_ok = ~flush & (((state == IDLE) & bypass) | (state == DONE));

    always_comb begin
        dataM = '0;
        if (data_ok) begin
            dataM.result  = dataE.result;
            dataM.ctl     = dataE.ctl;
            dataM.ex_data = dataE.ex_data;
            if (state == DONE && dataE.ctl.memread)
                dataM.readdata = XLEN'(ld_data);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_start)
                        state <= REQ;
                end
                REQ: begin
                    if (flush) begin
                        // Accepted but not yet returned: must absorb the response.
                        if (dresp_addr_ok && !dresp_data_ok)
                            state <= DRAIN;
                        else
                            state <= IDLE;
                    end else if (dresp_addr_ok) begin
                        if (dresp_data_ok) begin
                            rdata_q <= dresp_data;
                            state   <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dresp_data_ok) begin
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            rdata_q <= dresp_data;
                            state   <= DONE;
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                DRAIN: begin
                    if (dresp_data_ok)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;
    import memory_access_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          flush;
    execute_data_t dataE;
    logic          dreq_valid;
    logic [63:0]   dreq_addr;
    msize_t        dreq_size;
    logic [7:0]    dreq_strobe;
    logic [63:0]   dreq_data;
    logic          dresp_addr_ok;
    logic          dresp_data_ok;
    logic [63:0]   dresp_data;
    logic          data_ok;
    memory_data_t  dataM;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    memory_access #(.DW(64), .AW(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .flush         (flush),
        .dataE         (dataE),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .data_ok       (data_ok),
        .dataM         (dataM)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: byte-level view of the bus word.
    function automatic logic [7:0] m_strobe(input int off, input int n);
        logic [7:0] s = '0;
        for (int i = 0; i < n; i++)
            if (off + i < 8) s[off+i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] m_sdata(input logic [63:0] md, input int off);
        logic [63:0] r = '0;
        for (int j = off; j < 8; j++)
            r[8*j +: 8] = md[8*(j-off) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] raw, input int off, input int n, input logic uns);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++)
            if (off + i < 8) v[8*i +: 8] = raw[8*(off+i) +: 8];
        if (!uns && n < 8 && v[8*n-1])
            v = v - (64'd1 << (8*n));
        return v;
    endfunction

    task automatic set_op(input logic [63:0] addr, input logic [63:0] md, input logic rd,
                          input logic wr, input logic [1:0] sz, input logic uns, input logic exc);
        dataE.result           = addr;
        dataE.memdata          = md;
        dataE.ctl.memread      = rd;
        dataE.ctl.memwrite     = wr;
        dataE.ctl.msize        = msize_t'({1'b0, sz});
        dataE.ctl.mem_unsigned = uns;
        dataE.ex_data.exception = exc;
        dataE.ex_data.pc       = {$urandom, $urandom};
        dataE.ex_data.rd       = 5'($urandom);
        in_valid               = 1'b1;
    endtask

    // One instruction from IDLE to completion; ad = REQ cycles before accept,
    // dd = cycles between accept and data return (0 = same cycle).
    task automatic run_op(input string nm, input logic [63:0] addr, input logic [63:0] md,
                          input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic exc, input int ad, input int dd, input logic [63:0] raw);
        int n   = 1 << sz;
        int off = int'(addr[2:0]);
        logic byp = (!rd && !wr) || exc;
        @(negedge clk);
        set_op(addr, md, rd, wr, sz, uns, exc);
        #1;
        if (byp) begin
            chk({nm, ".byp_ok"}, 64'(data_ok), 64'd1);
            chk({nm, ".byp_req"}, 64'(dreq_valid), 64'd0);
            chk({nm, ".byp_rdata"}, dataM.readdata, 64'd0);
            chk({nm, ".byp_pc"}, dataM.ex_data.pc, dataE.ex_data.pc);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk({nm, ".byp_req2"}, 64'(dreq_valid), 64'd0);
            return;
        end
        chk({nm, ".idle_ok"}, 64'(data_ok), 64'd0);
        chk({nm, ".idle_req"}, 64'(dreq_valid), 64'd0);
        for (int k = 0; k <= ad; k++) begin
            @(negedge clk);
            if (k == ad) begin
                dresp_addr_ok = 1'b1;
                dresp_data_ok = (dd == 0);
                dresp_data    = (dd == 0) ? raw : {$urandom, $urandom};
            end
            #1;
            chk({nm, ".req_vld"}, 64'(dreq_valid), 64'd1);
            chk({nm, ".req_addr"}, dreq_addr, addr);
            chk({nm, ".req_size"}, 64'(dreq_size), 64'(sz));
            chk({nm, ".req_strb"}, 64'(dreq_strobe), wr ? 64'(m_strobe(off, n)) : 64'd0);
            if (wr) chk({nm, ".req_data"}, dreq_data, m_sdata(md, off));
            chk({nm, ".req_ok"}, 64'(data_ok), 64'd0);
        end
        for (int w = 1; w <= dd; w++) begin
            @(negedge clk);
            dresp_addr_ok = 1'b0;
            if (w == dd) begin
                dresp_data_ok = 1'b1;
                dresp_data    = raw;
            end
            #1;
            chk({nm, ".wait_vld"}, 64'(dreq_valid), 64'd0);
            chk({nm, ".wait_ok"}, 64'(data_ok), 64'd0);
        end
        @(negedge clk);
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = {$urandom, $urandom};
        in_valid      = 1'b0;
        #1;
        chk({nm, ".done_ok"}, 64'(data_ok), 64'd1);
        chk({nm, ".done_vld"}, 64'(dreq_valid), 64'd0);
        chk({nm, ".rdata"}, dataM.readdata, rd ? m_load(raw, off, n, uns) : 64'd0);
        @(negedge clk);
        #1;
        chk({nm, ".after_ok"}, 64'(data_ok), 64'd0);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; dataE = '0;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.vld", 64'(dreq_valid), 64'd0);
        chk("rst.ok", 64'(data_ok), 64'd0);
        chk("rst.strb", 64'(dreq_strobe), 64'd0);
        chk("rst.rdata", dataM.readdata, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("idle.noinvld_ok", 64'(data_ok), 64'd0);

        // Directed cases
        run_op("ld", 64'h8000_0008, 64'h0, 1, 0, 2'd3, 0, 0, 0, 0, 64'h1122_3344_5566_7788);
        run_op("lb", 64'h8000_0003, 64'h0, 1, 0, 2'd0, 0, 0, 0, 1, 64'h0000_0000_80FF_0000);
        run_op("lbu", 64'h8000_0003, 64'h0, 1, 0, 2'd0, 1, 0, 1, 0, 64'h0000_0000_80FF_0000);
        run_op("sh", 64'h8000_0006, 64'hABCD, 0, 1, 2'd1, 0, 0, 2, 0, 64'h0);
        run_op("add", 64'h1234, 64'h0, 0, 0, 2'd3, 0, 0, 0, 0, 64'h0);
        run_op("ld_exc", 64'h8000_0001, 64'h0, 1, 0, 2'd3, 0, 1, 0, 0, 64'h0);

        // Flush of a bypass instruction in IDLE
        @(negedge clk);
        set_op(64'h10, 64'h0, 0, 0, 2'd0, 0, 0);
        flush = 1'b1;
        #1;
        chk("fl_idle.ok", 64'(data_ok), 64'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;

        // Flush in REQ before accept
        @(negedge clk);
        set_op(64'h8000_0010, 64'h0, 1, 0, 2'd3, 0, 0);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fl_req.vld", 64'(dreq_valid), 64'd1);
        chk("fl_req.ok", 64'(data_ok), 64'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_req.drop", 64'(dreq_valid), 64'd0);

        // Flush in WAIT, drain, then next LW
        @(negedge clk);
        set_op(64'h8000_0020, 64'h0, 1, 0, 2'd3, 0, 0);
        @(negedge clk);
        dresp_addr_ok = 1'b1;
        @(negedge clk);
        dresp_addr_ok = 1'b0; flush = 1'b1;
        #1;
        chk("fl_wait.vld", 64'(dreq_valid), 64'd0);
        chk("fl_wait.ok", 64'(data_ok), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        set_op(64'h8000_0104, 64'h0, 1, 0, 2'd2, 0, 0);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("drain.vld", 64'(dreq_valid), 64'd0);
            chk("drain.ok", 64'(data_ok), 64'd0);
            @(negedge clk);
        end
        dresp_data_ok = 1'b1; dresp_data = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        chk("drain.late_ok", 64'(data_ok), 64'd0);
        run_op("lw_after", 64'h8000_0104, 64'h0, 1, 0, 2'd2, 0, 0, 0, 0, 64'hF234_5678_0000_0000);

        // Flush in DONE
        @(negedge clk);
        set_op(64'h8000_0030, 64'h0, 1, 0, 2'd3, 0, 0);
        @(negedge clk);
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h5;
        @(negedge clk);
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; flush = 1'b1;
        #1;
        chk("fl_done.ok", 64'(data_ok), 64'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_done.idle", 64'(dreq_valid), 64'd0);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            logic [1:0]  sz  = 2'($urandom_range(0, 3));
            int          kind = $urandom_range(0, 9);
            logic        exc = (kind == 9);
            logic        rd  = (kind < 5) || exc;
            logic        wr  = (kind >= 5 && kind < 8);
            logic [63:0] a   = {$urandom, $urandom};
            logic [2:0]  off = 3'(($urandom_range(0, 7) >> sz) << sz);
            if (exc) off = 3'd1 | off;
            a[2:0] = off;
            run_op("rnd", a, {$urandom, $urandom}, rd, wr, sz, 1'($urandom), exc,
                   $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom});
        end

        // Asynchronous reset while in REQ
        @(negedge clk);
        set_op(64'h8000_0040, 64'h0, 1, 0, 2'd3, 0, 0);
        @(negedge clk);
        #1;
        chk("arst.pre_vld", 64'(dreq_valid), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("arst.vld", 64'(dreq_valid), 64'd0);
        chk("arst.ok", 64'(data_ok), 64'd0);
        chk("arst.strb", 64'(dreq_strobe), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst.post_vld", 64'(dreq_valid), 64'd0);
        chk("arst.post_ok", 64'(data_ok), 64'd0);
        chk("arst.post_rdata", dataM.readdata, 64'd0);
        run_op("ld_post", 64'h8000_0050, 64'h0, 1, 0, 2'd1, 0, 0, 0, 0, 64'h0000_0000_0000_8001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
